transmit: RTL and testbench
===========================

Name: transmit

Overview:
- UART transmitter. Counterpart of the `recieve` block on the same serial link.
- Takes a byte written over the CPU-side IO strobe interface, serialises it onto `o_tx`, and holds every symbol for OVERSAMPLE pulses of `b_en`.
- `b_en` comes from the shared `brg` baud-rate generator: a one-clk pulse at 16x baud, e.g. divisor 0x028B for 9600 baud at 100 MHz.
- A one-entry holding buffer sits in front of the shift register, so back-to-back frames need no CPU stall.

Parameters:
- MSB_FIRST, 1: data bit order on the line. 1 = bit 7 first, matching the `recieve` block. 0 = bit 0 first.
- OVERSAMPLE, 16: `b_en` pulses per symbol. Power of 2, from 4 to 16.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- b_en  input  1  baud tick, one clk wide, OVERSAMPLE x baud
- i_iocs  input  1  chip select
- i_iorw  input  1  1 = read, 0 = write
- i_data  input  8  byte to send; sampled on a write
- o_tx  output  1  serial line; idles high
- o_tbr  output  1  transmit buffer ready: 1 = holding buffer empty
- o_busy  output  1  frame in progress (FSM not IDLE)

Behaviour:
- Reset: one clk with `rst`=1 forces the following:
  - `o_tx`=1, `o_tbr`=1, `o_busy`=0.
  - FSM=IDLE, holding buffer empty, tick and bit counters 0.
  - Reset mid-frame aborts the frame and drives the line high on the next clk.
- Write strobe: `i_iocs`=1 and `i_iorw`=0, sampled at posedge clk.
  - If `o_tbr`=1: latch `i_data` into the holding buffer; `o_tbr`=0 the next cycle.
  - If `o_tbr`=0: the write is ignored and the buffer is unchanged (no overwrite).
  - `i_iorw`=1 has no effect; this block has no readable registers.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when the optional feature is compiled in.
  - IDLE: `o_tx`=1. If the buffer is full, on the next posedge:
    - move buffer to shift register;
    - buffer becomes empty (`o_tbr`=1);
    - go to START; tick counter = 0.
    - Latency from an accepted write to `o_tx` falling: 2 clk.
  - START: `o_tx`=0.
  - DATA: `o_tx` = current data bit.
    - MSB_FIRST=1: shift register `[7]`, shift left on each bit boundary.
    - MSB_FIRST=0: `[0]`, shift right.
    - Bit counter runs 0..7; after bit 7, go to STOP (or PARITY).
  - STOP: `o_tx`=1. At the end of the symbol:
    - buffer full: load it and go directly to START on the same edge (back-to-back frame, no idle gap);
    - buffer empty: go to IDLE.
- Symbol timing:
  - Tick counter increments on each clk where `b_en`=1.
  - A symbol ends on the clk where `b_en`=1 and the tick counter = OVERSAMPLE-1. The counter then wraps to 0 and the state/bit advances on that edge.
  - Every symbol, including START, lasts exactly OVERSAMPLE `b_en` pulses.
  - Frame = 10 symbols = 160 `b_en` pulses at the default.
- `b_en` stuck low: FSM holds its state; the line holds its level.
- Simultaneous events:
  - Write on the same edge as a buffer-to-shift transfer: the write is ignored, because `o_tbr` was 0 when sampled.
  - `o_tbr` rising is the earliest point the next write is accepted.
- `o_busy` = (state != IDLE), registered.
- `o_tx` is registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TRANSMIT_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - `o_tx` = XOR of the 8 data bits (even parity) for OVERSAMPLE ticks.
  - Frame = 11 symbols.
- Undefined:
  - The PARITY state and its logic are absent.
  - DATA goes directly to STOP; frame = 10 symbols.

Test Plan:
- Reset: assert `rst` for 2 clk mid-frame (during DATA bit 3) -> next clk `o_tx`=1, `o_tbr`=1, `o_busy`=0; line stays high with no further activity.
- Single byte 0xA5, MSB_FIRST=1, brg divisor 0x028B:
  - `o_tx` falls 2 clk after the write;
  - line sequence 0,1,0,1,0,0,1,0,1,1, each symbol 16 `b_en` pulses;
  - loop `o_tx` into a `recieve` instance -> `o_rda`=1 with `o_data`=0xA5.
- Back-to-back: write 0x3C, then write 0xC3 once `o_tbr`=1 during the first frame.
  - Second frame's start bit begins on the same edge the first stop bit ends (zero idle clk).
  - `o_busy` stays 1 across both frames.
- Overrun: write 0x11, then 0x22 while `o_tbr`=1, then 0x33 while `o_tbr`=0 -> 0x11 and 0x22 are transmitted; 0x33 never appears.
- Read strobe: `i_iocs`=1, `i_iorw`=1 with `i_data`=0xFF -> no frame starts, `o_tbr` stays 1.
- With TRANSMIT_PARITY_EN: send 0x07 -> a parity symbol of 1 is inserted before the stop bit; frame lasts 176 `b_en` pulses.
- Loopback random: 100 `$urandom` bytes through `transmit` then `recieve` -> every received `o_data` equals the sent byte.

Source files
------------

// File: rtl/transmit.sv
// UART transmitter: one-entry holding buffer feeding a start/data/stop shift FSM paced by b_en.
// Optional even-parity symbol between data and stop when TRANSMIT_PARITY_EN is defined.
module transmit #(
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_en,
    input  logic       i_iocs,
    input  logic       i_iorw,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_tbr,
    output logic       o_busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);

`ifdef TRANSMIT_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e             state_q, state_d;
    logic [7:0]         buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [7:0]         shift_q, shift_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [2:0]         bit_q, bit_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               sym_end;
    logic               write_acc;
    logic               load;
`ifdef TRANSMIT_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign sym_end   = b_en && (tick_q == TickW'(OVERSAMPLE - 1));
    // A full buffer blocks writes, so a write and a transfer never share an edge.
    assign write_acc = i_iocs && !i_iorw && !buf_full_q;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        load       = 1'b0;
        tx_d       = 1'b1;
`ifdef TRANSMIT_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != StIdle && b_en) begin
            tick_d = sym_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    load    = 1'b1;
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (sym_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (sym_end) begin
                    shift_d = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef TRANSMIT_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef TRANSMIT_PARITY_EN
            StParity: begin
                if (sym_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (sym_end) begin
                    if (buf_full_q) begin
                        load    = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
`ifdef TRANSMIT_PARITY_EN
            parity_d   = ^buf_q;
`endif
        end
        if (write_acc) begin
            buf_d      = i_data;
            buf_full_d = 1'b1;
        end

        // Line level follows the current state, giving a registered output one clk behind.
        unique case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = MSB_FIRST ? shift_q[7] : shift_q[0];
`ifdef TRANSMIT_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            tick_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef TRANSMIT_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef TRANSMIT_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign o_tx   = tx_q;
    assign o_tbr  = !buf_full_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_transmit.sv
// Scoreboard bench for transmit: stimulus pushes expected bytes, a line monitor decodes and pops.
module tb_transmit;

    localparam int OS = 16;
`ifdef TRANSMIT_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_en;
    logic       i_iocs;
    logic       i_iorw;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tbr;
    logic       o_busy;
    int         bcnt = 0;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int frames = 0;
    int gap_cnt = 0;
    int last_gap = -1;

    transmit dut (
        .clk    (clk),
        .rst    (rst),
        .b_en   (b_en),
        .i_iocs (i_iocs),
        .i_iorw (i_iorw),
        .i_data (i_data),
        .o_tx   (o_tx),
        .o_tbr  (o_tbr),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    // Baud tick every third clk keeps the run short while exercising the same timing.
    always @(posedge clk) bcnt <= (bcnt == 2) ? 0 : bcnt + 1;
    assign b_en = (bcnt == 2);

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic next_pulse(output bit ab);
        do @(negedge clk); while (!b_en && !rst);
        ab = rst;
    endtask

    // Line monitor: sample o_tx on every b_en pulse, group OS samples per symbol.
    initial begin
        logic [NSYM-1:0] syms;
        logic [7:0]      data;
        logic [7:0]      exp;
        bit              ab;
        bit              stable;
        bit              framing;
        forever begin
            @(negedge clk);
            if (rst || !b_en) continue;
            if (o_tx) begin
                gap_cnt++;
                continue;
            end
            last_gap = gap_cnt;
            gap_cnt  = 0;
            syms     = '0;
            ab       = 1'b0;
            stable   = 1'b1;
            for (int s = 0; s < NSYM && !ab; s++) begin
                for (int p = 0; p < OS && !ab; p++) begin
                    if (s != 0 || p != 0) next_pulse(ab);
                    if (!ab) begin
                        if (p == 0) syms[s] = o_tx;
                        else if (o_tx !== syms[s]) stable = 1'b0;
                    end
                end
            end
            if (ab) continue;
            frames++;
            for (int i = 0; i < 8; i++) data[7-i] = syms[1+i];
            framing = stable && (syms[0] == 1'b0) && (syms[NSYM-1] == 1'b1);
`ifdef TRANSMIT_PARITY_EN
            framing = framing && (syms[9] == ^data);
`endif
            if (exp_q.size() == 0) begin
                check("unexpected_frame", data, -1);
            end else begin
                exp = exp_q.pop_front();
                check("frame_data", data, exp);
                check("frame_format", framing, 1);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [7:0] d, input logic rw);
        @(negedge clk);
        i_iocs = 1'b1;
        i_iorw = rw;
        i_data = d;
        @(posedge clk);
        #1;
        i_iocs = 1'b0;
        i_iorw = 1'b0;
    endtask

    task automatic wait_tbr();
        int n = 0;
        while (!o_tbr && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!o_tbr) check("tbr_timeout", o_tbr, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 4 * BOUND) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || o_busy) check("idle_timeout", exp_q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int  n;
        int  f0;
        bit  bad;
        logic [7:0] b;

        rst    = 1'b1;
        i_iocs = 1'b0;
        i_iorw = 1'b0;
        i_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", o_tx, 1);
        check("reset_tbr", o_tbr, 1);
        check("reset_busy", o_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single byte with write-to-start latency
        exp_q.push_back(8'hA5);
        do_write(8'hA5, 1'b0);
        check("write_tbr_low", o_tbr, 0);
        @(posedge clk);
        #1;
        check("latency_1clk_tx", o_tx, 1);
        @(posedge clk);
        #1;
        check("latency_2clk_tx", o_tx, 0);
        wait_idle();

        // Back-to-back frames: no idle gap, busy held
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        f0 = frames;
        do_write(8'h3C, 1'b0);
        wait_tbr();
        do_write(8'hC3, 1'b0);
        n = 0;
        while (!o_busy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        bad = 1'b0;
        n = 0;
        while (frames < f0 + 2 && n < 4 * BOUND) begin
            @(negedge clk);
            if (!o_busy) bad = 1'b1;
            n++;
        end
        check("b2b_busy_drop", bad, 0);
        check("b2b_gap", last_gap, 0);
        wait_idle();

        // Overrun: third write while buffer full is dropped
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        do_write(8'h11, 1'b0);
        wait_tbr();
        do_write(8'h22, 1'b0);
        do_write(8'h33, 1'b0);
        check("overrun_tbr", o_tbr, 0);
        wait_idle();
        check("overrun_frames_left", exp_q.size(), 0);

        // Read strobe does nothing
        f0 = frames;
        do_write(8'hFF, 1'b1);
        check("read_tbr", o_tbr, 1);
        repeat (100) @(negedge clk);
        check("read_busy", o_busy, 0);
        check("read_no_frame", frames, f0);

        // Reset during data bit 3
        f0 = frames;
        do_write(8'h5A, 1'b0);
        n = 0;
        while (o_tx && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (n < OS + 3 * OS + 8) begin
            @(negedge clk);
            if (b_en) n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx", o_tx, 1);
        check("midrst_tbr", o_tbr, 1);
        check("midrst_busy", o_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!o_tx || o_busy) bad = 1'b1;
        end
        check("midrst_quiet", bad, 0);
        check("midrst_no_frame", frames, f0);

`ifdef TRANSMIT_PARITY_EN
        exp_q.push_back(8'h07);
        do_write(8'h07, 1'b0);
        wait_idle();
`endif

        // Random loopback stream
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wait_tbr();
            do_write(b, 1'b0);
        end
        wait_idle();
        check("random_all_received", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
